// File: rtl/time_counter.sv
// Stopwatch/timer core: prescaled centisecond tick driving a cascaded
// hh:mm:ss.cc counter with up/down modes, saturating preload and lap capture.
module time_counter #(
  parameter int CS_DIV    = 100000,
  parameter int HOURS_MAX = 99,
  parameter int HR_W      = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            clear,
  input  logic            load,
  input  logic            count_up,
  input  logic            lap_req,
  input  logic [HR_W-1:0] ld_hr,
  input  logic [5:0]      ld_min,
  input  logic [5:0]      ld_sec,
  input  logic [6:0]      ld_cs,
  output logic [HR_W-1:0] hr,
  output logic [5:0]      min,
  output logic [5:0]      sec,
  output logic [6:0]      cs,
  output logic [HR_W-1:0] lap_hr,
  output logic [5:0]      lap_min,
  output logic [5:0]      lap_sec,
  output logic [6:0]      lap_cs,
  output logic            cs_tick,
  output logic            sec_tick,
  output logic            overflow,
  output logic            done
);

  localparam int PW = (CS_DIV > 2) ? $clog2(CS_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CS_DIV - 1);
  localparam logic [HR_W-1:0] HR_MAX     = HR_W'(HOURS_MAX);

  logic [PW-1:0]   presc;
  logic [HR_W-1:0] hr_nx;
  logic [5:0]      min_nx, sec_nx;
  logic [6:0]      cs_nx;
  logic            at_max, is_zero, nx_zero, ld_zero;

  function automatic logic [6:0] sat_cs(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  function automatic logic [5:0] sat_60(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  function automatic logic [HR_W-1:0] sat_hr(input logic [HR_W-1:0] v);
    return (v > HR_MAX) ? HR_MAX : v;
  endfunction

  assign cs_tick = enable && (presc == PRESC_LAST);
  assign at_max  = (hr == HR_MAX) && (min == 6'd59) && (sec == 6'd59) && (cs == 7'd99);
  assign is_zero = (hr == '0) && (min == '0) && (sec == '0) && (cs == '0);
  assign nx_zero = (hr_nx == '0) && (min_nx == '0) && (sec_nx == '0) && (cs_nx == '0);
  assign ld_zero = (ld_hr == '0) && (ld_min == '0) && (ld_sec == '0) && (ld_cs == '0);

  // Next field values for one centisecond step; down-count never wraps below zero.
  always_comb begin
    hr_nx  = hr;
    min_nx = min;
    sec_nx = sec;
    cs_nx  = cs;
    if (count_up) begin
      if (cs != 7'd99) cs_nx = cs + 7'd1;
      else begin
        cs_nx = '0;
        if (sec != 6'd59) sec_nx = sec + 6'd1;
        else begin
          sec_nx = '0;
          if (min != 6'd59) min_nx = min + 6'd1;
          else begin
            min_nx = '0;
            hr_nx  = (hr == HR_MAX) ? '0 : hr + 1'b1;
          end
        end
      end
    end else if (!is_zero) begin
      if (cs != 7'd0) cs_nx = cs - 7'd1;
      else begin
        cs_nx = 7'd99;
        if (sec != 6'd0) sec_nx = sec - 6'd1;
        else begin
          sec_nx = 6'd59;
          if (min != 6'd0) min_nx = min - 6'd1;
          else begin
            min_nx = 6'd59;
            hr_nx  = hr - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      hr       <= '0;
      min      <= '0;
      sec      <= '0;
      cs       <= '0;
      lap_hr   <= '0;
      lap_min  <= '0;
      lap_sec  <= '0;
      lap_cs   <= '0;
      sec_tick <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      overflow <= 1'b0;
      // Lap sees pre-update fields; a simultaneous clear overrides it below.
      if (lap_req) begin
        lap_hr  <= hr;
        lap_min <= min;
        lap_sec <= sec;
        lap_cs  <= cs;
      end
      if (clear) begin
        presc   <= '0;
        hr      <= '0;
        min     <= '0;
        sec     <= '0;
        cs      <= '0;
        lap_hr  <= '0;
        lap_min <= '0;
        lap_sec <= '0;
        lap_cs  <= '0;
        done    <= 1'b0;
      end else if (load) begin
        presc <= '0;
        hr    <= sat_hr(ld_hr);
        min   <= sat_60(ld_min);
        sec   <= sat_60(ld_sec);
        cs    <= sat_cs(ld_cs);
        done  <= !count_up && ld_zero;
      end else if (enable) begin
        presc <= cs_tick ? '0 : presc + 1'b1;
        if (cs_tick) begin
          hr  <= hr_nx;
          min <= min_nx;
          sec <= sec_nx;
          cs  <= cs_nx;
          if (count_up) begin
            done     <= 1'b0;
            overflow <= at_max;
            sec_tick <= (cs == 7'd99);
          end else if (is_zero) begin
            done <= 1'b1;
          end else begin
            done     <= nx_zero;
            sec_tick <= (cs == 7'd0);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios then random traffic, checked
// against a total-centisecond reference model.
module tb_time_counter;

  localparam int CS_DIV    = 4;
  localparam int HOURS_MAX = 99;
  localparam int HR_W      = 7;
  localparam int MAXT      = (HOURS_MAX + 1) * 360000 - 1;

  logic            clk = 1'b0;
  logic            rst, enable, clear, load, count_up, lap_req;
  logic [HR_W-1:0] ld_hr;
  logic [5:0]      ld_min, ld_sec;
  logic [6:0]      ld_cs;
  logic [HR_W-1:0] hr, lap_hr;
  logic [5:0]      min, sec, lap_min, lap_sec;
  logic [6:0]      cs, lap_cs;
  logic            cs_tick, sec_tick, overflow, done;

  int n_vec = 0;
  int n_err = 0;
  int m_total, m_pc, m_lap;
  bit m_done, m_ovf, m_st;

  time_counter #(.CS_DIV(CS_DIV), .HOURS_MAX(HOURS_MAX), .HR_W(HR_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .load(load),
    .count_up(count_up), .lap_req(lap_req),
    .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec), .ld_cs(ld_cs),
    .hr(hr), .min(min), .sec(sec), .cs(cs),
    .lap_hr(lap_hr), .lap_min(lap_min), .lap_sec(lap_sec), .lap_cs(lap_cs),
    .cs_tick(cs_tick), .sec_tick(sec_tick), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic check_model(input string p);
    chk({p, "_hr"},  hr,  m_total / 360000);
    chk({p, "_min"}, min, (m_total / 6000) % 60);
    chk({p, "_sec"}, sec, (m_total / 100) % 60);
    chk({p, "_cs"},  cs,  m_total % 100);
    chk({p, "_lap_hr"},  lap_hr,  m_lap / 360000);
    chk({p, "_lap_min"}, lap_min, (m_lap / 6000) % 60);
    chk({p, "_lap_sec"}, lap_sec, (m_lap / 100) % 60);
    chk({p, "_lap_cs"},  lap_cs,  m_lap % 100);
    chk({p, "_done"},     done,     m_done);
    chk({p, "_overflow"}, overflow, m_ovf);
    chk({p, "_sec_tick"}, sec_tick, m_st);
  endtask

  // One clock: check the combinational tick mid-cycle, predict the edge, check after it.
  task automatic cycle(input string p);
    int nt, npc, nlap;
    bit nd, no, ns, tick;
    @(negedge clk);
    tick = enable && (m_pc == CS_DIV - 1);
    chk({p, "_cs_tick"}, cs_tick, tick);
    nt = m_total; npc = m_pc; nlap = m_lap; nd = m_done; no = 0; ns = 0;
    if (lap_req) nlap = m_total;
    if (clear) begin
      nt = 0; npc = 0; nlap = 0; nd = 0;
    end else if (load) begin
      nt = ((sat(int'(ld_hr), HOURS_MAX) * 60 + sat(int'(ld_min), 59)) * 60
            + sat(int'(ld_sec), 59)) * 100 + sat(int'(ld_cs), 99);
      npc = 0;
      nd = !count_up && (nt == 0);
    end else if (enable) begin
      npc = (m_pc + 1) % CS_DIV;
      if (tick) begin
        if (count_up) begin
          nt = (m_total == MAXT) ? 0 : m_total + 1;
          no = (m_total == MAXT);
          nd = 0;
        end else if (m_total == 0) begin
          nd = 1;
        end else begin
          nt = m_total - 1;
          nd = (nt == 0);
        end
        ns = (nt / 100) != (m_total / 100);
      end
    end
    if (rst) begin
      nt = 0; npc = 0; nlap = 0; nd = 0; no = 0; ns = 0;
    end
    @(posedge clk);
    #1;
    m_total = nt; m_pc = npc; m_lap = nlap; m_done = nd; m_ovf = no; m_st = ns;
    check_model(p);
  endtask

  initial begin
    int stc, r, k;
    rst = 1'b1; enable = 1'b0; clear = 1'b0; load = 1'b0; count_up = 1'b1; lap_req = 1'b0;
    ld_hr = '0; ld_min = '0; ld_sec = '0; ld_cs = '0;
    m_total = 0; m_pc = 0; m_lap = 0; m_done = 0; m_ovf = 0; m_st = 0;
    cycle("reset");
    cycle("reset");
    rst = 1'b0;

    // Scenario 1: 400 clocks up from reset gives one second
    enable = 1'b1; count_up = 1'b1; stc = 0;
    repeat (400) begin cycle("t1"); stc += int'(sec_tick); end
    chk("t1_sec_final", sec, 1);
    chk("t1_cs_final", cs, 0);
    chk("t1_sec_tick_count", stc, 1);

    // Scenario 2: wrap from the maximum
    load = 1'b1; ld_hr = 7'd99; ld_min = 6'd59; ld_sec = 6'd59; ld_cs = 7'd99;
    cycle("t2_load");
    load = 1'b0;
    repeat (3) cycle("t2");
    cycle("t2_wrap");
    chk("t2_overflow", overflow, 1);
    chk("t2_hr_zero", hr, 0);
    chk("t2_done", done, 0);
    cycle("t2_after");
    chk("t2_overflow_pulse", overflow, 0);

    // Scenario 3: one-second countdown, then hold at zero
    count_up = 1'b0; load = 1'b1;
    ld_hr = '0; ld_min = '0; ld_sec = 6'd1; ld_cs = '0;
    cycle("t3_load");
    load = 1'b0; stc = 0;
    repeat (400) begin cycle("t3"); stc += int'(sec_tick); end
    chk("t3_done", done, 1);
    chk("t3_sec_tick_count", stc, 1);
    repeat (40) cycle("t3_hold");
    chk("t3_hold_cs", cs, 0);
    chk("t3_hold_done", done, 1);

    // Scenario 4: pause with prescaler at 2
    count_up = 1'b1; load = 1'b1; ld_sec = '0;
    cycle("t4_load");
    load = 1'b0;
    cycle("t4"); cycle("t4");
    enable = 1'b0;
    repeat (50) cycle("t4_pause");
    chk("t4_paused_cs", cs, 0);
    enable = 1'b1;
    cycle("t4_resume");
    cycle("t4_resume");
    chk("t4_resume_cs", cs, 1);

    // Scenario 5: lap capture on a tick edge, then lap together with clear
    load = 1'b1; ld_cs = 7'd49;
    cycle("t5_load");
    load = 1'b0;
    repeat (3) cycle("t5");
    lap_req = 1'b1;
    cycle("t5_lap");
    lap_req = 1'b0;
    chk("t5_lap_cs", lap_cs, 49);
    chk("t5_cs", cs, 50);
    lap_req = 1'b1; clear = 1'b1;
    cycle("t5_clear");
    lap_req = 1'b0; clear = 1'b0;
    chk("t5_clear_lap_cs", lap_cs, 0);

    // Scenario 6: saturating load, then asynchronous reset mid-count
    load = 1'b1; ld_hr = 7'd127; ld_min = 6'd0; ld_sec = 6'd63; ld_cs = 7'd120;
    cycle("t6_load");
    load = 1'b0;
    chk("t6_sat_hr", hr, 99);
    chk("t6_sat_sec", sec, 59);
    chk("t6_sat_cs", cs, 99);
    repeat (6) cycle("t6");
    #2 rst = 1'b1;
    #1;
    chk("t6_async_hr", hr, 0);
    chk("t6_async_min", min, 0);
    chk("t6_async_sec", sec, 0);
    chk("t6_async_cs", cs, 0);
    chk("t6_async_lap_cs", lap_cs, 0);
    chk("t6_async_cs_tick", cs_tick, 0);
    m_total = 0; m_pc = 0; m_lap = 0; m_done = 0; m_ovf = 0; m_st = 0;
    cycle("t6_rst");
    rst = 1'b0;

    // Random traffic with loads biased towards the wrap and zero boundaries
    repeat (2500) begin
      r = $urandom_range(0, 99);
      clear = (r < 2);
      load = (r >= 2) && (r < 7);
      enable = ($urandom_range(0, 9) != 0);
      lap_req = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 63) == 0) count_up = ~count_up;
      if (load) begin
        k = $urandom_range(0, 2);
        if (k == 0) begin
          ld_hr = 7'($urandom_range(0, 127)); ld_min = 6'($urandom_range(0, 63));
          ld_sec = 6'($urandom_range(0, 63)); ld_cs = 7'($urandom_range(0, 127));
        end else if (k == 1) begin
          ld_hr = 7'd99; ld_min = 6'd59; ld_sec = 6'd59; ld_cs = 7'($urandom_range(95, 99));
        end else begin
          ld_hr = '0; ld_min = '0; ld_sec = 6'($urandom_range(0, 1)); ld_cs = 7'($urandom_range(0, 5));
        end
      end
      cycle("rand");
    end
    clear = 1'b0; load = 1'b0; lap_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
